alu_arbiter: RTL

Shares one combinational `alu` instance (32-bit operands `a`, `b`, 3-bit function `f`, result `r`) between two independent requesters. Each requester issues an operation over a valid/ready handshake; the arbiter grants one request at a time, registers the operands, executes on the shared ALU, and returns the registered result with the requester's ID over a single valid/ready response channel. It sits between the two issuing units and the ALU; the ALU itself stays untouched.

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with its shared combinational alu)
// Brief    : Two requesters share one combinational ALU. A request is granted
//            in IDLE, its operands are registered, the ALU runs from those
//            registers in EXEC, and the registered result is held in RESP
//            until the consumer takes it.
// Options  : ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins
//            contention; when undefined (default), contention is round-robin.
// Revision : 1.0 - initial release
// ============================================================================

module alu #(
    parameter int WIDTH = 32,
    parameter int FW    = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [FW-1:0]    f,
    output logic [WIDTH-1:0] r
);

    localparam logic [FW-1:0] FN_AND  = FW'(3'b000);
    localparam logic [FW-1:0] FN_OR   = FW'(3'b001);
    localparam logic [FW-1:0] FN_ADD  = FW'(3'b010);
    localparam logic [FW-1:0] FN_ANDN = FW'(3'b100);
    localparam logic [FW-1:0] FN_ORN  = FW'(3'b101);
    localparam logic [FW-1:0] FN_SUB  = FW'(3'b110);
    localparam logic [FW-1:0] FN_SLT  = FW'(3'b111);

    // Decode the function code; arithmetic wraps, code 011 yields zero
    always_comb begin
        r = '0;
        case (f)
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_ADD:  r = a + b;
            FN_ANDN: r = a & ~b;
            FN_ORN:  r = a | ~b;
            FN_SUB:  r = a - b;
            FN_SLT:  r[0] = ($signed(a) < $signed(b));
            default: r = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [FW-1:0]    op_f_q, op_f_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
    logic             rsp_zero_q, rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    // Requester granted most recently; the other one wins the next tie
    logic             last_q, last_d;
`endif

    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] alu_r;

    // The shared ALU only ever sees the registered operands
    alu #(
        .WIDTH (WIDTH),
        .FW    (FW)
    ) u_alu (
        .a (op_a_q),
        .b (op_b_q),
        .f (op_f_q),
        .r (alu_r)
    );

    // Pick the requester to serve from the current valids
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_q;
`endif
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && grant_valid && !grant_id;
    assign req1_ready = (state_q == ST_IDLE) && grant_valid &&  grant_id;

    // Next-state and register updates for accept / execute / respond
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_f_d      = op_f_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_zero_d  = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    op_a_d  = grant_id ? req1_a : req0_a;
                    op_b_d  = grant_id ? req1_b : req0_b;
                    op_f_d  = grant_id ? req1_f : req0_f;
                    op_id_d = grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = grant_id;
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_r_d     = alu_r;
                rsp_zero_d  = (alu_r == '0);
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_f_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r_q     <= '0;
            rsp_zero_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_f_q      <= op_f_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_zero_q  <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire
